// File: rtl/a5_1_pixel_cipher_pkg.sv
// Shared types and default sizing for the A5/1 pixel cipher stage.
package a5_1_pkg;

  // Default geometry: 8-bit pixels, 256x256 frame, 16-bit pixel counter.
  localparam int DEF_PIXEL_W    = 8;
  localparam int DEF_NUM_PIXELS = 65536;
  localparam int DEF_CNT_W      = 16;

  // Control states of the cipher stage.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a bit index able to address every bit of a w-bit word.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/a5_1_pixel_cipher_if.sv
// Handshake bundle between keystream generator, pixel source, pixel sink and the cipher stage.
interface a5_1_pixel_cipher_if
  import a5_1_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int CNT_W   = DEF_CNT_W
);

  // keystream side
  logic               ks_bit;
  logic               ks_valid;
  logic               ks_ready;
  // plaintext side
  logic [PIXEL_W-1:0] pix_in;
  logic               pix_in_valid;
  logic               pix_in_ready;
  // ciphertext side
  logic [PIXEL_W-1:0] pix_out;
  logic               pix_out_valid;
  logic               pix_out_ready;
  // frame status
  logic [CNT_W-1:0]   pixel_count;
  logic               frame_done;

  // Environment view: drives stimulus, observes the stage.
  modport master (
    output ks_bit, ks_valid, pix_in, pix_in_valid, pix_out_ready,
    input  ks_ready, pix_in_ready, pix_out, pix_out_valid, pixel_count, frame_done
  );

  // Cipher stage view.
  modport slave (
    input  ks_bit, ks_valid, pix_in, pix_in_valid, pix_out_ready,
    output ks_ready, pix_in_ready, pix_out, pix_out_valid, pixel_count, frame_done
  );

endinterface

// File: rtl/a5_1_ks_byte_xor.sv
// Pixel data register with a bit index: XORs one keystream bit per consume, LSB first.
module a5_1_ks_byte_xor
  import a5_1_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PIXEL_W-1:0] pix_in,
  input  logic               ks_bit,
  input  logic               consume,
  output logic [PIXEL_W-1:0] data,
  output logic               last
);

  localparam int IDX_W = idx_width(PIXEL_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_W - 1);

  logic [IDX_W-1:0]   r_idx;
  logic [PIXEL_W-1:0] r_data;
  logic [PIXEL_W-1:0] w_flip;

  // One flip enable per data bit: only the bit selected by the index takes the keystream bit.
  generate
    for (genvar gi = 0; gi < PIXEL_W; gi++) begin : g_flip
      assign w_flip[gi] = consume & ks_bit & (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Bit index: cleared on load, advances on each consumed keystream bit, wraps after the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (load) begin
      r_idx <= '0;
    end else if (consume) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Data register: captures the plaintext on load, then accumulates keystream flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= pix_in;
    end else begin
      r_data <= r_data ^ w_flip;
    end
  end

  assign data = r_data;
  assign last = (r_idx == IDX_LAST);

endmodule

// File: rtl/a5_1_pixel_cipher.sv
// A5/1 pixel cipher stage: accepts a pixel, mixes in PIXEL_W keystream bits, emits ciphertext,
// counts delivered pixels and flags a completed frame.
module a5_1_pixel_cipher
  import a5_1_pkg::*;
#(
  parameter int PIXEL_W    = DEF_PIXEL_W,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  a5_1_pixel_cipher_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIXELS - 1);

  state_t             r_state;
  state_t             w_state_next;

  // Ready/valid outputs are registered copies of the next-state decode, so no input
  // reaches them combinationally and all of them read 0 in the cycle after reset.
  logic               r_pix_in_ready;
  logic               r_ks_ready;
  logic               r_pix_out_valid;
  logic               w_pix_in_ready_next;
  logic               w_ks_ready_next;
  logic               w_pix_out_valid_next;

  logic [CNT_W-1:0]   r_pixel_count;
  logic               r_frame_done;

  logic               w_accept;
  logic               w_consume;
  logic               w_handshake;
  logic               w_last_bit;
  logic               w_last_pixel;
  logic [PIXEL_W-1:0] w_data;

  assign w_accept     = r_pix_in_ready  & bus.pix_in_valid;
  assign w_consume    = r_ks_ready      & bus.ks_valid;
  assign w_handshake  = r_pix_out_valid & bus.pix_out_ready;
  assign w_last_pixel = (r_pixel_count == CNT_LAST);

  a5_1_ks_byte_xor #(
    .PIXEL_W (PIXEL_W)
  ) u_ks_byte_xor (
    .clk     (clk),
    .reset   (reset),
    .load    (w_accept),
    .pix_in  (bus.pix_in),
    .ks_bit  (bus.ks_bit),
    .consume (w_consume),
    .data    (w_data),
    .last    (w_last_bit)
  );

  // State and handshake output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pix_in_ready  <= 1'b0;
      r_ks_ready      <= 1'b0;
      r_pix_out_valid <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pix_in_ready  <= w_pix_in_ready_next;
      r_ks_ready      <= w_ks_ready_next;
      r_pix_out_valid <= w_pix_out_valid_next;
    end
  end

  // Next-state logic: one pixel at a time, no overlap between pixels.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = MIX;
      MIX:     if (w_consume && w_last_bit) w_state_next = OUT;
      OUT:     if (w_handshake) w_state_next = w_last_pixel ? DONE : IDLE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the state about to be entered.
  always_comb begin
    w_pix_in_ready_next  = 1'b0;
    w_ks_ready_next      = 1'b0;
    w_pix_out_valid_next = 1'b0;
    case (w_state_next)
      IDLE:    w_pix_in_ready_next  = 1'b1;
      MIX:     w_ks_ready_next      = 1'b1;
      OUT:     w_pix_out_valid_next = 1'b1;
      default: ;
    endcase
  end

  // Pixel counter and sticky frame-complete flag, advanced on each ciphertext handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_count <= '0;
      r_frame_done  <= 1'b0;
    end else if (w_handshake) begin
      if (w_last_pixel) begin
        r_pixel_count <= '0;
        r_frame_done  <= 1'b1;
      end else begin
        r_pixel_count <= r_pixel_count + 1'b1;
      end
    end
  end

  assign bus.pix_in_ready  = r_pix_in_ready;
  assign bus.ks_ready      = r_ks_ready;
  assign bus.pix_out_valid = r_pix_out_valid;
  assign bus.pix_out       = w_data;
  assign bus.pixel_count   = r_pixel_count;
  assign bus.frame_done    = r_frame_done;

endmodule

// File: tb/tb_a5_1_pixel_cipher.sv
// Self-checking bench: directed table/sequences on a 4-pixel frame, random full frame on a 256-pixel frame.
module tb_a5_1_pixel_cipher;
  import a5_1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  a5_1_pixel_cipher_if #(.PIXEL_W(8), .CNT_W(16)) ifa ();
  a5_1_pixel_cipher_if #(.PIXEL_W(8), .CNT_W(8))  ifb ();

  a5_1_pixel_cipher #(.PIXEL_W(8), .NUM_PIXELS(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  a5_1_pixel_cipher #(.PIXEL_W(8), .NUM_PIXELS(256), .CNT_W(8)) u_dut_frame (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  typedef struct {
    logic [7:0] pix;
    logic [7:0] ks;
    logic [7:0] exp;
  } vec_t;

  vec_t       frame_tab [4];
  logic [7:0] q_exp_a [$];
  logic [7:0] q_pix_b [$];
  logic       q_bits_b [$];
  int         hs_a = 0;
  int         hs_b = 0;
  int         done_rises = 0;
  logic       done_b_prev = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: keystream bit k flips plaintext bit k.
  function automatic logic [7:0] cipher_model(input logic [7:0] p, input logic [7:0] ks);
    logic [7:0] r;
    r = p;
    for (int k = 0; k < 8; k++) r[k] = r[k] ^ ks[k];
    return r;
  endfunction

  // Scoreboard for the small frame: pop expected ciphertext on each output handshake.
  always @(negedge clk) begin
    if (!rst && ifa.pix_out_valid && ifa.pix_out_ready) begin
      logic [7:0] e;
      hs_a++;
      checks++;
      if (q_exp_a.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_a: got %0h expected no output", ifa.pix_out);
      end else begin
        e = q_exp_a.pop_front();
        if (ifa.pix_out !== e) begin
          errors++;
          $display("FAIL pix_out_a: got %0h expected %0h", ifa.pix_out, e);
        end
      end
      $display("A out #%0d pix_out=%0h", hs_a, ifa.pix_out);
    end
  end

  // Scoreboard for the random frame: expected built from accepted pixels and consumed bits.
  always @(negedge clk) begin
    if (!rst && ifb.pix_out_valid && ifb.pix_out_ready) begin
      logic [7:0] p;
      logic [7:0] ks;
      logic [7:0] e;
      hs_b++;
      checks++;
      if (q_pix_b.size() == 0 || q_bits_b.size() < 8) begin
        errors++;
        $display("FAIL unexpected_out_b: got %0h with %0d pixels %0d bits queued", ifb.pix_out,
                 q_pix_b.size(), q_bits_b.size());
      end else begin
        p = q_pix_b.pop_front();
        for (int k = 0; k < 8; k++) ks[k] = q_bits_b.pop_front();
        e = cipher_model(p, ks);
        if (ifb.pix_out !== e) begin
          errors++;
          $display("FAIL pix_out_b #%0d: got %0h expected %0h", hs_b, ifb.pix_out, e);
        end
      end
    end
    if (ifb.frame_done && !done_b_prev) done_rises++;
    done_b_prev = ifb.frame_done;
  end

  // Drive one pixel into the small DUT and feed its 8 keystream bits (optionally every other cycle).
  task automatic send_pixel(input logic [7:0] p, input logic [7:0] ks, input logic [7:0] exp,
                            input bit gap, output int cycles, output int bad);
    int w = 0;
    int k = 0;
    cycles = 0;
    bad = 0;
    while (!ifa.pix_in_ready && w < 40) begin
      tick();
      w++;
    end
    if (!ifa.pix_in_ready) begin
      checks++;
      errors++;
      $display("FAIL pix_in_ready_timeout: got 0 expected 1");
      return;
    end
    ifa.pix_in       = p;
    ifa.pix_in_valid = 1'b1;
    q_exp_a.push_back(exp);
    $display("A in pix=%0h ks=%0h gap=%0d", p, ks, gap);
    tick();
    ifa.pix_in_valid = 1'b0;
    ifa.pix_in       = 8'h00;
    while (k < 8 && cycles < 40) begin
      ifa.ks_valid = gap ? (cycles % 2 == 0) : 1'b1;
      ifa.ks_bit   = ks[k];
      if (!ifa.ks_ready || ifa.pix_out_valid) bad++;
      if (ifa.ks_ready && ifa.ks_valid) k++;
      tick();
      cycles++;
    end
    ifa.ks_valid = 1'b0;
    ifa.ks_bit   = 1'b0;
    if (k < 8) begin
      checks++;
      errors++;
      $display("FAIL ks_consume_timeout: got %0d bits expected 8", k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_out"},       ifa.pix_out, 8'h00);
    chk({tag, "_pix_out_valid"}, ifa.pix_out_valid, 1'b0);
    chk({tag, "_pix_in_ready"},  ifa.pix_in_ready, 1'b0);
    chk({tag, "_ks_ready"},      ifa.ks_ready, 1'b0);
    chk({tag, "_pixel_count"},   ifa.pixel_count, 16'd0);
    chk({tag, "_frame_done"},    ifa.frame_done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int bad;
    int viol;
    int hs_before;
    int cyc;
    bit accepted;
    logic [7:0] held;

    frame_tab[0] = '{pix: 8'h00, ks: 8'h01, exp: 8'h01};
    frame_tab[1] = '{pix: 8'h00, ks: 8'h02, exp: 8'h02};
    frame_tab[2] = '{pix: 8'h00, ks: 8'h03, exp: 8'h03};
    frame_tab[3] = '{pix: 8'h00, ks: 8'h04, exp: 8'h04};

    ifa.ks_bit = 1'b0; ifa.ks_valid = 1'b0; ifa.pix_in = 8'h00;
    ifa.pix_in_valid = 1'b0; ifa.pix_out_ready = 1'b0;
    ifb.ks_bit = 1'b0; ifb.ks_valid = 1'b0; ifb.pix_in = 8'h00;
    ifb.pix_in_valid = 1'b0; ifb.pix_out_ready = 1'b0;

    // Reset values, then IDLE readiness.
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_pix_in_ready", ifa.pix_in_ready, 1'b1);

    // 0xA5 with keystream 0x01 back-to-back: valid 9 cycles after accept.
    ifa.pix_out_ready = 1'b1;
    send_pixel(8'hA5, 8'h01, 8'hA4, 1'b0, cycles, bad);
    chk("a5_mix_cycles", cycles, 8);
    chk("a5_mix_ready_no_early_valid", bad, 0);
    chk("a5_valid_at_accept_plus_9", ifa.pix_out_valid, 1'b1);
    chk("a5_pix_out", ifa.pix_out, 8'hA4);
    tick();
    chk("a5_pixel_count", ifa.pixel_count, 16'd1);
    chk("a5_valid_dropped", ifa.pix_out_valid, 1'b0);
    chk("a5_back_to_idle", ifa.pix_in_ready, 1'b1);

    // 0xFF with ks_valid toggling, then a 20-cycle output stall.
    ifa.pix_out_ready = 1'b0;
    send_pixel(8'hFF, 8'hFF, 8'h00, 1'b1, cycles, bad);
    chk("gap_cycles", cycles, 15);
    chk("gap_ks_ready_held", bad, 0);
    chk("gap_valid", ifa.pix_out_valid, 1'b1);
    chk("gap_pix_out", ifa.pix_out, 8'h00);
    held = ifa.pix_out;
    viol = 0;
    ifa.pix_in       = 8'h55;
    ifa.pix_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ifa.pix_out_valid || ifa.pix_out !== held || ifa.ks_ready || ifa.pix_in_ready) viol++;
    end
    chk("stall_hold", viol, 0);
    ifa.pix_in_valid  = 1'b0;
    hs_before         = hs_a;
    ifa.pix_out_ready = 1'b1;
    tick();
    chk("release_valid_low", ifa.pix_out_valid, 1'b0);
    chk("release_idle", ifa.pix_in_ready, 1'b1);
    chk("release_count", ifa.pixel_count, 16'd2);
    tick();
    tick();
    chk("release_single_handshake", hs_a - hs_before, 1);
    chk("release_queue_empty", q_exp_a.size(), 0);

    // Reset after 4 of 8 keystream bits: pixel discarded, outputs at reset values.
    ifa.pix_in       = 8'h77;
    ifa.pix_in_valid = 1'b1;
    tick();
    ifa.pix_in_valid = 1'b0;
    ifa.ks_valid     = 1'b1;
    ifa.ks_bit       = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst          = 1'b1;
    ifa.ks_valid = 1'b0;
    ifa.ks_bit   = 1'b0;
    tick();
    check_reset_outputs("midmix");
    rst = 1'b0;
    send_pixel(8'h3C, 8'h00, 8'h3C, 1'b0, cycles, bad);
    chk("post_reset_pix_out", ifa.pix_out, 8'h3C);
    tick();
    chk("post_reset_count", ifa.pixel_count, 16'd1);

    // Four-pixel frame from the table: counter wrap and frame completion.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      send_pixel(frame_tab[i].pix, frame_tab[i].ks, frame_tab[i].exp, 1'b0, cycles, bad);
      chk("frame_pix_out", ifa.pix_out, frame_tab[i].exp);
      tick();
      chk("frame_count", ifa.pixel_count, 16'((i + 1) % 4));
      chk("frame_done", ifa.frame_done, (i == 3));
    end
    hs_before        = hs_a;
    ifa.pix_in       = 8'hEE;
    ifa.pix_in_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifa.pix_in_ready || ifa.ks_ready || ifa.pix_out_valid || !ifa.frame_done) viol++;
    end
    ifa.pix_in_valid = 1'b0;
    chk("done_ignores_input", viol, 0);
    chk("done_no_output", hs_a - hs_before, 0);
    chk("done_count_zero", ifa.pixel_count, 16'd0);

    // Random full frame of 256 pixels with random keystream gaps and sink stalls.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ifb.pix_in       = 8'($urandom);
    ifb.pix_in_valid = 1'b1;
    cyc = 0;
    while (hs_b < 256 && cyc < 20000) begin
      ifb.ks_valid      = ($urandom_range(0, 3) != 0);
      ifb.ks_bit        = 1'($urandom_range(0, 1));
      ifb.pix_out_ready = ($urandom_range(0, 3) != 0);
      if (ifb.ks_valid && ifb.ks_ready) q_bits_b.push_back(ifb.ks_bit);
      accepted = ifb.pix_in_valid && ifb.pix_in_ready;
      if (accepted) q_pix_b.push_back(ifb.pix_in);
      tick();
      cyc++;
      if (accepted) ifb.pix_in = 8'($urandom);
    end
    chk("frame_b_all_delivered", hs_b, 256);
    for (int i = 0; i < 10; i++) tick();
    $display("B frame delivered=%0d cycles=%0d", hs_b, cyc);
    chk("frame_b_done", ifb.frame_done, 1'b1);
    chk("frame_b_done_once", done_rises, 1);
    chk("frame_b_count_wrap", ifb.pixel_count, 8'd0);
    chk("frame_b_no_extra", hs_b, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
